// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting clients and the round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) returns the grant.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    modport master (output req, input gnt, gnt_idx, gnt_valid);
    modport slave  (input req, output gnt, gnt_idx, gnt_valid);
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot and encoded grant.
// A hold counter caps how long one owner keeps the resource while others wait.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  arb
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [7:0] gnt_q, gnt_nxt;
    logic [2:0] idx_q, idx_nxt;

    logic [7:0] others;
    pick_t      win_all, win_oth;
    logic       grant_en;
    logic [2:0] grant_w;

    // First set bit of vec scanning start, start+1, ... with 3-bit wrap.
    function automatic pick_t rr_pick(input logic [7:0] vec, input logic [2:0] start);
        pick_t      p;
        logic [2:0] k;
        p = '0;
        for (int i = 7; i >= 0; i--) begin
            k = start + 3'(i);
            if (vec[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

    // The registered owner index doubles as gnt_idx while in GRANT.
    assign others  = arb.req & ~(8'b1 << idx_q);
    assign win_all = rr_pick(arb.req, ptr);
    assign win_oth = rr_pick(others, ptr);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        gnt_nxt   = gnt_q;
        idx_nxt   = idx_q;
        grant_en  = 1'b0;
        grant_w   = '0;

        unique case (state)
            IDLE: begin
                if (win_all.found) begin
                    grant_en = 1'b1;
                    grant_w  = win_all.idx;
                end
            end
            GRANT: begin
                if (!arb.req[idx_q]) begin
                    if (win_oth.found) begin
                        grant_en = 1'b1;
                        grant_w  = win_oth.idx;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        idx_nxt   = '0;
                        hold_nxt  = '0;
                    end
                end else if (hold_cnt < MAX_HOLD_C) begin
                    hold_nxt = hold_cnt + 8'd1;
                end else if (win_oth.found) begin
                    grant_en = 1'b1;
                    grant_w  = win_oth.idx;
                end
                // Owner still requesting at the limit with nobody waiting: saturate.
            end
            default: state_nxt = IDLE;
        endcase

        if (grant_en) begin
            state_nxt = GRANT;
            ptr_nxt   = grant_w + 3'd1;
            hold_nxt  = 8'd1;
            gnt_nxt   = 8'b1 << grant_w;
            idx_nxt   = grant_w;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt_q    <= '0;
            idx_q    <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gnt_q    <= gnt_nxt;
            idx_q    <= idx_nxt;
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_idx   = idx_q;
    assign arb.gnt_valid = (state == GRANT);

    a_gnt_consistent: assert property (@(posedge clk) disable iff (rst)
        $onehot0(arb.gnt) && (arb.gnt_valid == (|arb.gnt)) &&
        (arb.gnt_valid ? (arb.gnt == (8'b1 << arb.gnt_idx)) : (arb.gnt_idx == 3'd0)));

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized plus directed bench for rr_arbiter8 using a queue-based scoreboard
// fed by a behavioural ownership model.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_arbiter8_if arb_if ();

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb_if)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Behavioural model: owner is -1 when nobody holds the resource.
    int m_owner  = -1;
    int m_ptr    = 0;
    int m_tenure = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total_cnt++;
        if (act === req_v) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req_v, $time);
    endtask

    function automatic int pick(input logic [7:0] v, input int start);
        for (int i = 0; i < 8; i++) begin
            if (v[(start + i) % 8]) return (start + i) % 8;
        end
        return -1;
    endfunction

    function automatic void take(input int w);
        m_owner  = w;
        m_ptr    = (w + 1) % 8;
        m_tenure = 1;
    endfunction

    function automatic void model_edge(input logic [7:0] r, input logic rs);
        logic [7:0] rest;
        int         w;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_tenure = 0;
            return;
        end
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) take(w);
            return;
        end
        rest = r;
        rest[m_owner] = 1'b0;
        w = pick(rest, m_ptr);
        if (!r[m_owner]) begin
            if (w >= 0) take(w);
            else m_owner = -1;
        end else if (m_tenure < MAX_HOLD) begin
            m_tenure++;
        end else if (w >= 0) begin
            take(w);
        end
    endfunction

    // One clock of stimulus: drive at negedge, evaluate model at the edge, queue the result.
    task automatic step(input logic [7:0] r, input logic rs);
        exp_t e;
        @(negedge clk);
        arb_if.req = r;
        rst        = rs;
        @(posedge clk);
        model_edge(r, rs);
        e.valid = (m_owner >= 0);
        e.gnt   = e.valid ? (8'b1 << m_owner) : 8'h00;
        e.idx   = e.valid ? 3'(m_owner) : 3'd0;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are stable at the falling edge; pop one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt",       32'(arb_if.gnt),       32'(e.gnt));
                check("gnt_idx",   32'(arb_if.gnt_idx),   32'(e.idx));
                check("gnt_valid", 32'(arb_if.gnt_valid), 32'(e.valid));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        arb_if.req = 8'h00;

        // Reset with every client requesting, then first grant goes to client 0.
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b0);

        // Release handoff: owner drops req for a cycle; order 0..7 then wrap to 0.
        for (int i = 0; i < 9; i++) begin
            r = 8'hFF;
            if (m_owner >= 0) r[m_owner] = 1'b0;
            step(r, 1'b0);
        end

        // Single client held well beyond MAX_HOLD, then dropped.
        step(8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step(8'h04, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // Preemption between clients 3 and 5.
        for (int i = 0; i < 12; i++) step(8'h28, 1'b0);
        step(8'h00, 1'b0);

        // Search start from ptr=6 after client 5 was served.
        step(8'h00, 1'b1);
        step(8'h20, 1'b0);
        step(8'h41, 1'b0);
        step(8'h01, 1'b0);
        step(8'h00, 1'b0);

        // Reset while client 4 holds with hold count 2.
        step(8'h00, 1'b1);
        step(8'h10, 1'b0);
        step(8'h10, 1'b0);
        step(8'h12, 1'b1);
        step(8'h12, 1'b0);
        step(8'h12, 1'b0);
        step(8'h00, 1'b0);

        // Random traffic with sticky requests and occasional reset.
        r = 8'h00;
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            if (m_owner >= 0 && $urandom_range(0, 5) == 0) r[m_owner] = 1'b0;
            step(r, ($urandom_range(0, 149) == 0));
        end
        step(8'h00, 1'b0);

        // Let the monitor drain the queue.
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
